// File: rtl/alu_regbank_pkg.sv
// Shared types and default sizing for the register bank with clear sweep.
package alu_regbank_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_REG_CNT = 8;

endpackage

// File: rtl/alu_regbank_clrseq.sv
// Clear sequencer: walks the register index 0..REG_CNT-1, one per cycle.
// Latency: busy the cycle after clr_req, REG_CNT cycles, then a 1-cycle clr_done.
// Backpressure: none; clr_req is ignored while a sweep is running.
module alu_regbank_clrseq
    import alu_regbank_pkg::*;
#(
    parameter int REG_CNT = DEF_REG_CNT,
    parameter int AW      = $clog2(REG_CNT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done,
    output logic [AW-1:0] clr_idx,
    output logic          clr_stb
);

    localparam logic [AW-1:0] LAST = AW'(REG_CNT - 1);

    clr_state_t    state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            clr_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state == CLEAR);
    assign clr_stb = busy;
    assign clr_idx = cnt;

endmodule

// File: rtl/alu_regbank.sv
// Register bank: one write port, two combinational read ports, valid bits, clear sweep.
// Latency: reads zero-cycle (optional same-cycle write forwarding), writes commit at clk.
// Backpressure: writes and clear requests are dropped while the clear sweep is busy.
module alu_regbank
    import alu_regbank_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_CNT = DEF_REG_CNT,
    parameter int AW      = $clog2(REG_CNT),
    parameter bit ZERO_R0 = 1'b0,
    parameter bit BYPASS  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [AW-1:0]     wrt_slct,
    input  logic              wrtnbl,
    input  logic [AW-1:0]     rd_slct_a,
    input  logic [AW-1:0]     rd_slct_b,
    input  logic              clr_req,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    output logic              vld_a,
    output logic              vld_b,
    output logic              busy,
    output logic              clr_done
);

    logic [DATA_W-1:0]  regs [REG_CNT];
    logic [REG_CNT-1:0] valid;
    logic [AW-1:0]      clr_idx;
    logic               clr_stb;
    logic               wr_ok;

    alu_regbank_clrseq #(
        .REG_CNT (REG_CNT),
        .AW      (AW)
    ) u_clrseq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .clr_idx  (clr_idx),
        .clr_stb  (clr_stb)
    );

    // Out-of-range indices only exist when REG_CNT is not a power of two.
    assign wr_ok = wrtnbl && !busy && (int'(wrt_slct) < REG_CNT)
                   && !(ZERO_R0 && (wrt_slct == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
            valid <= '0;
        end else if (clr_stb) begin
            regs[clr_idx]  <= '0;
            valid[clr_idx] <= 1'b0;
        end else if (wr_ok) begin
            regs[wrt_slct]  <= data_in;
            valid[wrt_slct] <= 1'b1;
        end
    end

    always_comb begin
        data_out_a = '0;
        vld_a      = 1'b0;
        if (int'(rd_slct_a) < REG_CNT) begin
            data_out_a = regs[rd_slct_a];
            vld_a      = valid[rd_slct_a];
        end
        if (ZERO_R0 && (rd_slct_a == '0)) begin
            data_out_a = '0;
            vld_a      = 1'b1;
        end else if (BYPASS && wr_ok && (rd_slct_a == wrt_slct)) begin
            data_out_a = data_in;
            vld_a      = 1'b1;
        end
    end

    always_comb begin
        data_out_b = '0;
        vld_b      = 1'b0;
        if (int'(rd_slct_b) < REG_CNT) begin
            data_out_b = regs[rd_slct_b];
            vld_b      = valid[rd_slct_b];
        end
        if (ZERO_R0 && (rd_slct_b == '0)) begin
            data_out_b = '0;
            vld_b      = 1'b1;
        end else if (BYPASS && wr_ok && (rd_slct_b == wrt_slct)) begin
            data_out_b = data_in;
            vld_b      = 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_regbank.sv
// Bench for alu_regbank: instance 0 is the default build, instance 1 is REG_CNT=6, ZERO_R0=1, BYPASS=0.
module tb_alu_regbank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wen, clr;
    logic [2:0] wsel, ra, rb;
    logic [7:0] din;

    logic [7:0] act_da [2];
    logic [7:0] act_db [2];
    logic       act_va [2];
    logic       act_vb [2];
    logic       act_busy [2];
    logic       act_done [2];

    int errors = 0;
    int checks = 0;

    // Reference state: plain arrays plus a sweep position per instance.
    int unsigned m_reg  [2][8];
    bit          m_vld  [2][8];
    bit          m_busy [2];
    int          m_pos  [2];
    bit          m_done [2];
    int          busy_cnt [2];
    int          done_cnt [2];

    typedef struct {
        bit w; int ws; int d; int a; int b;
        int ea; bit eva; int eb; bit evb;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    alu_regbank dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(din), .wrt_slct(wsel), .wrtnbl(wen),
        .rd_slct_a(ra), .rd_slct_b(rb), .clr_req(clr),
        .data_out_a(act_da[0]), .data_out_b(act_db[0]), .vld_a(act_va[0]), .vld_b(act_vb[0]),
        .busy(act_busy[0]), .clr_done(act_done[0])
    );

    alu_regbank #(.REG_CNT(6), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(din), .wrt_slct(wsel), .wrtnbl(wen),
        .rd_slct_a(ra), .rd_slct_b(rb), .clr_req(clr),
        .data_out_a(act_da[1]), .data_out_b(act_db[1]), .vld_a(act_va[1]), .vld_b(act_vb[1]),
        .busy(act_busy[1]), .clr_done(act_done[1])
    );

    function automatic int cnt_of(int k);
        return (k == 0) ? 8 : 6;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void exp_read(int k, int idx, output int d, output int v);
        d = 0;
        v = 0;
        if (k == 1 && idx == 0) begin
            v = 1;
            return;
        end
        if (idx >= cnt_of(k)) return;
        if (k == 0 && wen && !m_busy[k] && idx == int'(wsel)) begin
            d = int'(din);
            v = 1;
            return;
        end
        d = int'(m_reg[k][idx]);
        v = int'(m_vld[k][idx]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[k][i] = 0;
                m_vld[k][i] = 0;
            end
            m_busy[k] = 0;
            m_pos[k]  = 0;
            m_done[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (m_busy[k]) begin
                m_reg[k][m_pos[k]] = 0;
                m_vld[k][m_pos[k]] = 0;
                if (m_pos[k] == cnt_of(k) - 1) begin
                    m_busy[k] = 0;
                    m_done[k] = 1;
                end else begin
                    m_pos[k]++;
                    m_done[k] = 0;
                end
            end else begin
                m_done[k] = 0;
                if (wen && int'(wsel) < cnt_of(k) && !(k == 1 && wsel == 0)) begin
                    m_reg[k][wsel] = din;
                    m_vld[k][wsel] = 1;
                end
                if (clr) begin
                    m_busy[k] = 1;
                    m_pos[k]  = 0;
                end
            end
        end
    endtask

    task automatic set_in(bit w, int ws, int d, int a, int b, bit c);
        wen  = w;
        wsel = 3'(ws);
        din  = 8'(d);
        ra   = 3'(a);
        rb   = 3'(b);
        clr  = c;
    endtask

    task automatic sample();
        int d, v;
        #2;
        for (int k = 0; k < 2; k++) begin
            exp_read(k, int'(ra), d, v);
            chk($sformatf("data_a%0d", k), int'(act_da[k]), d);
            chk($sformatf("vld_a%0d", k), int'(act_va[k]), v);
            exp_read(k, int'(rb), d, v);
            chk($sformatf("data_b%0d", k), int'(act_db[k]), d);
            chk($sformatf("vld_b%0d", k), int'(act_vb[k]), v);
            chk($sformatf("busy%0d", k), int'(act_busy[k]), int'(m_busy[k]));
            chk($sformatf("clr_done%0d", k), int'(act_done[k]), int'(m_done[k]));
            if (act_busy[k]) busy_cnt[k]++;
            if (act_done[k]) done_cnt[k]++;
        end
    endtask

    task automatic clock();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(act_busy[0]), 0);
        chk("rst_done", int'(act_done[0]), 0);
        rst_n = 1'b1;

        // Empty bank after reset, every index on both ports.
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 0, i, 7 - i, 0);
            sample();
            chk("reset_read_a", int'(act_da[0]), 0);
            chk("reset_vld_b", int'(act_vb[0]), 0);
            clock();
        end

        tbl[0] = '{0, 0, 8'h00, 0, 7, 8'h00, 0, 8'h00, 0};
        tbl[1] = '{1, 6, 8'h01, 6, 6, 8'h01, 1, 8'h01, 1};
        tbl[2] = '{0, 0, 8'h00, 6, 5, 8'h01, 1, 8'h00, 0};
        tbl[3] = '{1, 3, 8'hC3, 3, 6, 8'hC3, 1, 8'h01, 1};
        tbl[4] = '{0, 0, 8'h00, 3, 3, 8'hC3, 1, 8'hC3, 1};
        tbl[5] = '{1, 6, 8'h7E, 6, 3, 8'h7E, 1, 8'hC3, 1};
        tbl[6] = '{0, 0, 8'h00, 6, 0, 8'h7E, 1, 8'h00, 0};
        for (int i = 0; i < 7; i++) begin
            set_in(tbl[i].w, tbl[i].ws, tbl[i].d, tbl[i].a, tbl[i].b, 0);
            sample();
            chk($sformatf("tbl%0d_da", i), int'(act_da[0]), tbl[i].ea);
            chk($sformatf("tbl%0d_va", i), int'(act_va[0]), int'(tbl[i].eva));
            chk($sformatf("tbl%0d_db", i), int'(act_db[0]), tbl[i].eb);
            chk($sformatf("tbl%0d_vb", i), int'(act_vb[0]), int'(tbl[i].evb));
            clock();
        end

        // Fill, sweep, and try to write / restart while busy.
        for (int i = 0; i < 8; i++) begin
            set_in(1, i, 8'h10 + i, i, 7 - i, 0);
            sample();
            clock();
        end
        busy_cnt = '{0, 0};
        done_cnt = '{0, 0};
        set_in(0, 0, 0, 0, 1, 1);
        sample();
        clock();
        for (int c = 0; c < 10; c++) begin
            set_in(c < 8, 7, 8'hAA, $urandom_range(0, 7), $urandom_range(0, 7), c == 3);
            sample();
            clock();
        end
        chk("sweep_busy_cycles0", busy_cnt[0], 8);
        chk("sweep_done_pulses0", done_cnt[0], 1);
        chk("sweep_busy_cycles1", busy_cnt[1], 6);
        chk("sweep_done_pulses1", done_cnt[1], 1);
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 0, i, i, 0);
            sample();
            chk("post_sweep_data", int'(act_da[0]), 0);
            chk("post_sweep_vld", int'(act_va[0]), 0);
            clock();
        end

        // Write and clear request in the same idle cycle.
        set_in(1, 2, 8'h99, 2, 2, 1);
        sample();
        clock();
        for (int c = 0; c < 9; c++) begin
            set_in(0, 0, 0, 2, 1, 0);
            sample();
            clock();
        end
        set_in(0, 0, 0, 2, 2, 0);
        sample();
        chk("wr_then_clr_data", int'(act_da[0]), 0);
        chk("wr_then_clr_vld", int'(act_va[0]), 0);
        clock();

        // Register 0 hardwired on instance 1; index 7 out of range there.
        set_in(1, 0, 8'hFF, 0, 0, 0);
        sample();
        clock();
        sample();
        chk("r0_data", int'(act_da[1]), 0);
        chk("r0_vld", int'(act_va[1]), 1);
        clock();
        set_in(1, 7, 8'h55, 7, 7, 0);
        sample();
        clock();
        sample();
        chk("oor_data", int'(act_da[1]), 0);
        chk("oor_vld", int'(act_vb[1]), 0);
        clock();

        // Reset in the middle of a sweep.
        for (int i = 0; i < 8; i++) begin
            set_in(1, i, 8'h20 + i, i, i, 0);
            sample();
            clock();
        end
        set_in(0, 0, 0, 0, 0, 1);
        sample();
        clock();
        set_in(0, 0, 0, 5, 6, 0);
        for (int c = 0; c < 3; c++) begin
            sample();
            clock();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        done_cnt = '{0, 0};
        #1;
        chk("abort_busy0", int'(act_busy[0]), 0);
        chk("abort_busy1", int'(act_busy[1]), 0);
        chk("abort_done0", int'(act_done[0]), 0);
        chk("abort_data", int'(act_da[0]), 0);
        repeat (2) begin
            @(negedge clk);
            if (act_done[0] || act_done[1]) done_cnt[0]++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 0, i, 7 - i, 0);
            sample();
            clock();
        end
        chk("abort_no_done0", done_cnt[0], 0);
        chk("abort_no_done1", done_cnt[1], 0);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255),
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 24) == 0);
            sample();
            clock();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
